// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Owns the fetch PC and issues word fetches over a req/gnt/rvalid port.
// Returned words are queued in order, together with their PCs, for decode.
// A redirect flushes the queue and discards any responses still in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  // Pointer, occupancy, in-flight counter and credit-sum widths
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_C   = SW'(DEPTH);

  // Architectural state
  logic [31:0]   fetch_pc_reg,    fetch_pc_next;
  logic [31:0]   resp_pc_reg,     resp_pc_next;
  logic [OW-1:0] outstanding_reg, outstanding_next;
  logic [OW-1:0] drop_cnt_reg,    drop_cnt_next;
  logic [CW-1:0] count_reg,       count_next;
  logic [PW-1:0] wr_ptr_reg,      wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg,      rd_ptr_next;

  // Queue storage: no reset needed, the head is masked while the queue is empty
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];

  // Handshake and bookkeeping terms
  logic [31:0]   redirect_tgt;
  logic [SW-1:0] credit_sum;
  logic          fire_req;
  logic          resp_keep;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  // The low two target bits are forced to zero: fetches are always word aligned
  assign redirect_tgt = redirect_pc_i & ~32'h0000_0003;

  // Entries already queued plus responses that will be queued; a request is
  // only raised when a slot is guaranteed, so the queue can never overflow
  assign credit_sum = SW'(count_reg) + SW'(outstanding_reg) - SW'(drop_cnt_reg);

  assign imem_req_o  = !rst_i && !redirect_i &&
                       (outstanding_reg < MAX_OUT_C) && (credit_sum < DEPTH_C);
  assign imem_addr_o = fetch_pc_reg;

  assign fire_req   = imem_req_o && imem_gnt_i;
  assign resp_keep  = imem_rvalid_i && (drop_cnt_reg == '0);
  assign fifo_empty = (count_reg == '0);

  // A redirect cancels any push or pop in its cycle since the queue is flushed
  assign push = resp_keep && !redirect_i;

  assign instr_valid_o = !fifo_empty && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i;

  // Head is read straight from storage; zero while nothing is queued
  assign instr_o    = fifo_empty ? 32'h0 : mem_instr[rd_ptr_reg];
  assign instr_pc_o = fifo_empty ? 32'h0 : mem_pc[rd_ptr_reg];

  // Next-state computation for PCs, counters and queue pointers
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;

    // In-flight requests: a grant and a response in one cycle cancel out
    case ({fire_req, imem_rvalid_i})
      2'b10:   outstanding_next = outstanding_reg + OW'(1);
      2'b01:   outstanding_next = outstanding_reg - OW'(1);
      default: outstanding_next = outstanding_reg;
    endcase

    if (redirect_i) begin
      // Everything still in flight belongs to the old path and must be dropped
      fetch_pc_next = redirect_tgt;
      resp_pc_next  = redirect_tgt;
      drop_cnt_next = outstanding_reg - OW'(imem_rvalid_i);
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      if (fire_req) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end

      if (imem_rvalid_i && (drop_cnt_reg != '0)) begin
        drop_cnt_next = drop_cnt_reg - OW'(1);
      end

      if (push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        wr_ptr_next  = wr_ptr_reg + PW'(1);
      end

      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end

      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // Queue write: store the returned word with the PC it was fetched from
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_instr[wr_ptr_reg] <= imem_rdata_i;
      mem_pc[wr_ptr_reg]    <= resp_pc_reg;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// u_dut uses the default RESET_PC with a queue-based memory model whose
// responses can be held back; u_dut_wrap uses RESET_PC near the top of the
// address space with a fixed one-cycle memory.
module tb_instr_fetch_unit;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 signals
  logic        rst         = 1'b1;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt         = 1'b0;
  logic        rvalid      = 1'b0;
  logic [31:0] rdata       = 32'h0;
  logic        ivalid;
  logic        ready       = 1'b0;
  logic [31:0] instr;
  logic [31:0] ipc;

  // Instance 2 signals
  logic        rst2         = 1'b1;
  logic        redirect2    = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        req2;
  logic [31:0] addr2;
  logic        gnt2         = 1'b1;
  logic        rv2          = 1'b0;
  logic [31:0] rd2          = 32'h0;
  logic        valid2;
  logic        ready2       = 1'b1;
  logic [31:0] instr2;
  logic [31:0] pc2;

  // Memory model controls
  logic        hold = 1'b0;
  int          gcnt = 0;
  logic [31:0] rq [$];

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_unit u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (ivalid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (ipc)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_PC)) u_dut_wrap (
    .clk_i         (clk),
    .rst_i         (rst2),
    .redirect_i    (redirect2),
    .redirect_pc_i (redirect_pc2),
    .imem_req_o    (req2),
    .imem_addr_o   (addr2),
    .imem_gnt_i    (gnt2),
    .imem_rvalid_i (rv2),
    .imem_rdata_i  (rd2),
    .instr_valid_o (valid2),
    .instr_ready_i (ready2),
    .instr_o       (instr2),
    .instr_pc_o    (pc2)
  );

  // Instruction word the memory holds at a given address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  // Memory model for u_dut: in-order responses, earliest one cycle after grant
  always @(posedge clk) begin
    if (rst) begin
      rq.delete();
      rvalid <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      if (imem_req && gnt) begin
        rq.push_back(imem_addr);
        gcnt <= gcnt + 1;
      end
      if (!hold && rq.size() != 0) begin
        rvalid <= 1'b1;
        rdata  <= mem_word(rq.pop_front());
      end else begin
        rvalid <= 1'b0;
      end
    end
  end

  // Memory model for u_dut_wrap: always granted, one-cycle response
  always @(posedge clk) begin
    if (rst2) begin
      rv2 <= 1'b0;
      rd2 <= 32'h0;
    end else begin
      rv2 <= req2;
      rd2 <= mem_word(addr2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = 1'b0; hold = 1'b0; ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g0;

    // ---------------- Reset state
    cyc(); settle();
    chk("rst_req",   imem_req,  32'd0);
    chk("rst_valid", ivalid,    32'd0);
    chk("rst_instr", instr,     32'h0);
    chk("rst_pc",    ipc,       32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    cyc();

    // ---------------- Test 1: streaming fetch, ready=1
    rst = 1'b0; gnt = 1'b1; ready = 1'b1; settle();
    chk("t1_req_c1",  imem_req,  32'd1);
    chk("t1_addr_c1", imem_addr, 32'h0);
    cyc(); settle();
    chk("t1_addr_c2",  imem_addr, 32'h4);
    chk("t1_valid_c2", ivalid,    32'd0);
    cyc(); settle();
    chk("t1_addr_c3",  imem_addr, 32'h8);
    chk("t1_valid_c3", ivalid,    32'd1);
    chk("t1_pc_c3",    ipc,       32'h0);
    chk("t1_instr_c3", instr,     mem_word(32'h0));
    cyc(); settle();
    chk("t1_pc_c4", ipc, 32'h4);
    cyc(); settle();
    chk("t1_pc_c5",    ipc,   32'h8);
    chk("t1_instr_c5", instr, mem_word(32'h8));
    $display("t1 streaming done");

    // ---------------- Test 2: backpressure fills queue
    do_reset();
    g0 = gcnt;
    rst = 1'b0; gnt = 1'b1; ready = 1'b0; settle();   // A
    cyc(); cyc(); cyc(); cyc(); settle();             // E
    chk("t2_req_E", imem_req, 32'd0);
    cyc(); settle();                                  // F
    chk("t2_req_F",   imem_req,          32'd0);
    chk("t2_grants",  32'(gcnt - g0),    32'd4);
    chk("t2_valid_F", ivalid,            32'd1);
    chk("t2_head_F",  ipc,               32'h0);
    cyc(); settle();                                  // G
    chk("t2_hold_pc",    ipc,   32'h0);
    chk("t2_hold_instr", instr, mem_word(32'h0));
    ready = 1'b1; settle();
    chk("t2_req_G", imem_req, 32'd0);
    cyc(); settle();                                  // H
    chk("t2_req_H",  imem_req,  32'd1);
    chk("t2_addr_H", imem_addr, 32'h10);
    chk("t2_pc_H",   ipc,       32'h4);
    cyc(); settle();
    chk("t2_pc_I", ipc, 32'h8);
    cyc(); settle();
    chk("t2_pc_J", ipc, 32'hC);
    cyc(); settle();
    chk("t2_pc_K",    ipc,   32'h10);
    chk("t2_instr_K", instr, mem_word(32'h10));
    $display("t2 backpressure done");

    // ---------------- Test 3: redirect with two requests in flight
    do_reset();
    rst = 1'b0; gnt = 1'b1; ready = 1'b1; hold = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h20; settle();  // A
    chk("t3_req_redir", imem_req, 32'd0);
    cyc(); redirect = 1'b0; settle();                 // B
    chk("t3_addr_B", imem_addr, 32'h20);
    cyc(); settle();                                  // C
    chk("t3_addr_C", imem_addr, 32'h24);
    cyc(); settle();                                  // D
    chk("t3_req_full", imem_req, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h103; settle();
    chk("t3_valid_D", ivalid, 32'd0);
    cyc(); redirect = 1'b0; hold = 1'b0; settle();    // E
    chk("t3_addr_E",  imem_addr, 32'h100);
    chk("t3_req_E",   imem_req,  32'd0);
    chk("t3_valid_E", ivalid,    32'd0);
    cyc(); settle();                                  // F
    chk("t3_valid_F", ivalid,   32'd0);
    chk("t3_req_F",   imem_req, 32'd0);
    cyc(); settle();                                  // G
    chk("t3_valid_G", ivalid,    32'd0);
    chk("t3_req_G",   imem_req,  32'd1);
    chk("t3_addr_G",  imem_addr, 32'h100);
    cyc(); settle();                                  // H
    chk("t3_valid_H", ivalid, 32'd0);
    cyc(); settle();                                  // I
    chk("t3_valid_I", ivalid, 32'd1);
    chk("t3_pc_I",    ipc,    32'h100);
    chk("t3_instr_I", instr,  mem_word(32'h100));
    $display("t3 redirect in flight done");

    // ---------------- Test 4: redirect coincident with rvalid
    do_reset();
    rst = 1'b0; gnt = 1'b1; ready = 1'b0; settle();   // A
    cyc(); hold = 1'b1; settle();                     // B
    cyc(); hold = 1'b0; settle();                     // C
    chk("t4_valid_C", ivalid, 32'd1);
    chk("t4_pc_C",    ipc,    32'h0);
    cyc(); settle();                                  // D
    chk("t4_rvalid_D", rvalid, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40; settle();
    chk("t4_valid_D", ivalid,   32'd0);
    chk("t4_req_D",   imem_req, 32'd0);
    cyc(); redirect = 1'b0; settle();                 // E
    chk("t4_valid_E", ivalid,    32'd0);
    chk("t4_req_E",   imem_req,  32'd1);
    chk("t4_addr_E",  imem_addr, 32'h40);
    cyc(); settle();                                  // F
    chk("t4_valid_F", ivalid, 32'd0);
    cyc(); settle();                                  // G
    chk("t4_valid_G", ivalid, 32'd1);
    chk("t4_pc_G",    ipc,    32'h40);
    chk("t4_instr_G", instr,  mem_word(32'h40));
    $display("t4 redirect with rvalid done");

    // ---------------- Test 5: grant withheld
    do_reset();
    g0 = gcnt;
    rst = 1'b0; gnt = 1'b0; ready = 1'b1; settle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_req_%0d", i),   imem_req,  32'd1);
      chk($sformatf("t5_addr_%0d", i),  imem_addr, 32'h0);
      chk($sformatf("t5_valid_%0d", i), ivalid,    32'd0);
      cyc(); settle();
    end
    chk("t5_grants", 32'(gcnt - g0), 32'd0);
    $display("t5 grant stall done");

    // ---------------- Test 6: address wrap and mid-stream reset
    rst2 = 1'b0; settle();                            // A
    chk("t6_req_A",  req2,  32'd1);
    chk("t6_addr_A", addr2, 32'hFFFF_FFF8);
    cyc(); settle();                                  // B
    chk("t6_addr_B", addr2, 32'hFFFF_FFFC);
    cyc(); settle();                                  // C
    chk("t6_addr_C",  addr2,  32'h0000_0000);
    chk("t6_valid_C", valid2, 32'd1);
    chk("t6_pc_C",    pc2,    32'hFFFF_FFF8);
    chk("t6_instr_C", instr2, mem_word(32'hFFFF_FFF8));
    cyc(); settle();                                  // D
    chk("t6_addr_D", addr2, 32'h0000_0004);
    chk("t6_pc_D",   pc2,   32'hFFFF_FFFC);
    rst2 = 1'b1; settle();
    cyc(); settle();                                  // E
    chk("t6_rst_req",   req2,   32'd0);
    chk("t6_rst_valid", valid2, 32'd0);
    chk("t6_rst_instr", instr2, 32'h0);
    chk("t6_rst_pc",    pc2,    32'h0);
    chk("t6_rst_addr",  addr2,  32'hFFFF_FFF8);
    $display("t6 wrap and reset done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
